// File: rtl/write_port_arbiter_pkg.sv
// Shared constants and output-stage type for the register-file write port arbiter.
// Holds default widths, the zero-register address and the output-stage struct.
package write_port_arbiter_pkg;

    localparam int WPA_DATA_WIDTH = 32;
    localparam int WPA_ADDR_WIDTH = 5;
    localparam int WPA_NUM_REQ    = 4;
    localparam int WPA_ZERO_ADDR  = 0;
    localparam int WPA_ID_WIDTH   = $clog2(WPA_NUM_REQ);

    typedef struct packed {
        logic                      valid;
        logic [WPA_ADDR_WIDTH-1:0] addr;
        logic [WPA_DATA_WIDTH-1:0] data;
        logic [WPA_ID_WIDTH-1:0]   id;
    } wpa_slot_t;

endpackage

// File: rtl/write_port_arbiter_picker.sv
// Combinational rotating-priority picker: first valid at or after ptr_i, wrapping.
// Ports: valid_i, ptr_i in; one-hot grant_o and binary idx_o out.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic found;
    int   j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && valid_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/write_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ producers.
// Ports: clock/reset, per-requester valid/addr/data with one-hot ready, and a
// one-slot output stage (valid/addr/data/id) drained by write_ready_in.
// Macro WRITE_PORT_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority.
module write_port_arbiter
    import write_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = WPA_DATA_WIDTH,
    parameter int ADDR_WIDTH = WPA_ADDR_WIDTH,
    parameter int NUM_REQ    = WPA_NUM_REQ
) (
    input  logic                            write_port_arbiter_clock_in,
    input  logic                            write_port_arbiter_reset_in,
    input  logic [NUM_REQ-1:0]              req_valid_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_in,
    output logic [NUM_REQ-1:0]              req_ready_out,
    input  logic                            write_ready_in,
    output logic                            write_valid_out,
    output logic [ADDR_WIDTH-1:0]           write_addr_out,
    output logic [DATA_WIDTH-1:0]           write_data_out,
    output logic [$clog2(NUM_REQ)-1:0]      write_id_out
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      id_q, id_d;
    logic [IDX_W-1:0]      ptr;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      win;
    logic                  slot_free;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

`ifdef WRITE_PORT_ARBITER_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    assign ptr = rr_ptr_q;
`endif

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid_i (req_valid_in),
        .ptr_i   (ptr),
        .grant_o (grant),
        .idx_o   (win)
    );

    assign slot_free = !valid_q || write_ready_in;

    // Ready is forced low during reset so nothing is accepted then lost.
    assign req_ready_out = write_port_arbiter_reset_in
                         ? (grant & {NUM_REQ{slot_free}}) : '0;
    assign hs = |(req_ready_out & req_valid_in);

    assign sel_addr = req_addr_in[win*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = req_data_in[win*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        id_d    = id_q;
        if (write_ready_in) begin
            valid_d = 1'b0;
        end
        // Writes to register 0 are accepted but never reach the slot.
        if (hs && (sel_addr != ADDR_WIDTH'(WPA_ZERO_ADDR))) begin
            valid_d = 1'b1;
            addr_d  = sel_addr;
            data_d  = sel_data;
            id_d    = win;
        end
    end

`ifndef WRITE_PORT_ARBITER_FIXED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
        end
    end
`endif

    always_ff @(posedge write_port_arbiter_clock_in) begin
        if (!write_port_arbiter_reset_in) begin
            valid_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            id_q     <= '0;
`ifndef WRITE_PORT_ARBITER_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            id_q     <= id_d;
`ifndef WRITE_PORT_ARBITER_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign write_valid_out = valid_q;
    assign write_addr_out  = addr_q;
    assign write_data_out  = data_q;
    assign write_id_out    = id_q;

endmodule

// File: tb/tb_write_port_arbiter.sv
// Scoreboard bench for write_port_arbiter: directed vectors push expected writes,
// a monitor pops and compares each write the register file consumes.
module tb_write_port_arbiter;
    import write_port_arbiter_pkg::*;

    localparam int N  = WPA_NUM_REQ;
    localparam int AW = WPA_ADDR_WIDTH;
    localparam int DW = WPA_DATA_WIDTH;
    localparam int IW = WPA_ID_WIDTH;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*AW-1:0]  req_addr;
    logic [N*DW-1:0]  req_data;
    logic [N-1:0]     req_ready;
    logic             wr_ready;
    logic             wr_valid;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [IW-1:0]    wr_id;

    logic [AW-1:0]    addr_t [N];
    logic [DW-1:0]    data_t [N];

    wpa_slot_t        exp_q [$];
    int               checks;
    int               errors;

    write_port_arbiter dut (
        .write_port_arbiter_clock_in (clk),
        .write_port_arbiter_reset_in (rst_n),
        .req_valid_in                (req_valid),
        .req_addr_in                 (req_addr),
        .req_data_in                 (req_data),
        .req_ready_out               (req_ready),
        .write_ready_in              (wr_ready),
        .write_valid_out             (wr_valid),
        .write_addr_out              (wr_addr),
        .write_data_out              (wr_data),
        .write_id_out                (wr_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = addr_t[i];
            req_data[i*DW +: DW] = data_t[i];
        end
    end

    // Monitor: every consumed write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && wr_valid && wr_ready) begin
            wpa_slot_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL consume_unexpected: got addr=%0d data=%h id=%0d, want none",
                         wr_addr, wr_data, wr_id);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data || wr_id !== e.id) begin
                    errors++;
                    $display("FAIL consume: got addr=%0d data=%h id=%0d, want addr=%0d data=%h id=%0d",
                             wr_addr, wr_data, wr_id, e.addr, e.data, e.id);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // One cycle: drive, check ready and slot valid at negedge, push expectation.
    task automatic cyc(input logic [N-1:0] v, input logic wr,
                       input logic [N-1:0] rdy_exp, input logic wv_exp);
        wpa_slot_t e;
        req_valid = v;
        wr_ready  = wr;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(rdy_exp));
        chk("write_valid", 64'(wr_valid), 64'(wv_exp));
        for (int i = 0; i < N; i++) begin
            if (rdy_exp[i] && addr_t[i] != '0) begin
                e.valid = 1'b1;
                e.addr  = addr_t[i];
                e.data  = data_t[i];
                e.id    = IW'(i);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        for (int i = 0; i < N; i++) begin
            addr_t[i] = AW'(5 + i);
            data_t[i] = DW'(32'h100 + i);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        wr_ready  = 1'b0;
        set_defaults();

        // Reset: ready stays low even with all requesters valid.
        cyc(4'b1111, 1'b1, 4'b0000, 1'b0);
        cyc(4'b1111, 1'b1, 4'b0000, 1'b0);
        rst_n = 1'b1;
        chk("rst_addr", 64'(wr_addr), 64'd0);
        chk("rst_data", 64'(wr_data), 64'd0);
        chk("rst_id", 64'(wr_id), 64'd0);

        // Reset mid-write.
        addr_t[0] = AW'(5);
        data_t[0] = 32'hDEADBEEF;
        cyc(4'b0001, 1'b0, 4'b0001, 1'b0);
        chk("held_addr", 64'(wr_addr), 64'd5);
        chk("held_data", 64'(wr_data), 64'hDEADBEEF);
        rst_n = 1'b0;
        cyc(4'b0000, 1'b0, 4'b0000, 1'b1);
        rst_n = 1'b1;
        exp_q.delete();
        chk("rst2_addr", 64'(wr_addr), 64'd0);
        chk("rst2_data", 64'(wr_data), 64'd0);
        chk("rst2_id", 64'(wr_id), 64'd0);
        set_defaults();

        // All valid: 0,1,2,3,0 back to back; rr_ptr restarted at 0.
        cyc(4'b1111, 1'b1, 4'b0001, 1'b0);
        cyc(4'b1111, 1'b1, 4'b0010, 1'b1);
        cyc(4'b1111, 1'b1, 4'b0100, 1'b1);
        cyc(4'b1111, 1'b1, 4'b1000, 1'b1);
        cyc(4'b1111, 1'b1, 4'b0001, 1'b1);
        cyc(4'b0000, 1'b1, 4'b0000, 1'b1);
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0);

        // Register-0 write from requester 2 is dropped; search resumes at 3.
        addr_t[2] = '0;
        data_t[2] = 32'h1234;
        cyc(4'b0100, 1'b1, 4'b0100, 1'b0);
        cyc(4'b1111, 1'b1, 4'b1000, 1'b0);
        cyc(4'b0000, 1'b1, 4'b0000, 1'b1);
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0);
        set_defaults();

        // Back-pressure with requester 1 waiting.
        cyc(4'b0010, 1'b0, 4'b0010, 1'b0);
        addr_t[1] = AW'(9);
        data_t[1] = 32'h555;
        cyc(4'b0010, 1'b0, 4'b0000, 1'b1);
        chk("bp_addr", 64'(wr_addr), 64'd6);
        chk("bp_data", 64'(wr_data), 64'h101);
        cyc(4'b0010, 1'b0, 4'b0000, 1'b1);
        chk("bp_id", 64'(wr_id), 64'd1);
        cyc(4'b0010, 1'b1, 4'b0010, 1'b1);
        cyc(4'b0000, 1'b1, 4'b0000, 1'b1);
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0);

        // Wrap-around: pointer at 2, then 3 beats 0, then 0.
        cyc(4'b0100, 1'b1, 4'b0100, 1'b0);
        cyc(4'b1001, 1'b1, 4'b1000, 1'b1);
        cyc(4'b1001, 1'b1, 4'b0001, 1'b1);
        cyc(4'b0000, 1'b1, 4'b0000, 1'b1);
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0);

        // Register-0 grant while the slot drains leaves it empty.
        cyc(4'b0010, 1'b1, 4'b0010, 1'b0);
        addr_t[2] = '0;
        cyc(4'b0100, 1'b1, 4'b0100, 1'b1);
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0);
        set_defaults();

        // Requesters 1 and 3 continuously valid; pointer now at 3.
`ifdef WRITE_PORT_ARBITER_FIXED_PRIO_EN
        cyc(4'b1010, 1'b1, 4'b0010, 1'b0);
        cyc(4'b1010, 1'b1, 4'b0010, 1'b1);
        cyc(4'b1010, 1'b1, 4'b0010, 1'b1);
        cyc(4'b1010, 1'b1, 4'b0010, 1'b1);
`else
        cyc(4'b1010, 1'b1, 4'b1000, 1'b0);
        cyc(4'b1010, 1'b1, 4'b0010, 1'b1);
        cyc(4'b1010, 1'b1, 4'b1000, 1'b1);
        cyc(4'b1010, 1'b1, 4'b0010, 1'b1);
`endif
        cyc(4'b0000, 1'b1, 4'b0000, 1'b1);
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0);
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
